sipo_deser: RTL

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser_pkg.sv | 20 ++
 rtl/sipo_bit_cnt.sv | 38 +++
 rtl/sipo_deser.sv | 114 +++++++++++
 3 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the serial-in / parallel-out deserializer.
package sipo_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WIDTH_DEFAULT = 4;

    // Bits needed to hold values 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Bit-position counter for the word being assembled; wraps to 0 after WIDTH-1.
module sipo_bit_cnt
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int            CW     = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_V = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // clr together with inc means "this bit is bit 0 of a fresh word".
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            if (clr)       cnt_d = CW'(1);
            else if (last) cnt_d = '0;
            else           cnt_d = cnt_q + CW'(1);
        end else if (clr) begin
            cnt_d = '0;
        end
    end

    assign last = (cnt_q == LAST_V);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-word hold register, valid/ready
// handshake, and sticky overrun / framing-error flags.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_en,
    input  logic             start,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic cnt_last;
    logic restart;
    logic word_done;

    sipo_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .inc  (s_en),
        .last (cnt_last)
    );

    always_comb begin
        sh_d = sh_q;
        if (s_en) begin
            if (MSB_FIRST) sh_d = {sh_q[WIDTH-2:0], s_in};
            else           sh_d = {s_in, sh_q[WIDTH-1:1]};
        end
    end

    // A start inside a word wins over completion: the partial word is dropped.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        word_done = 1'b0;
        if (s_en) begin
            case (state_q)
                IDLE:  state_d = SHIFT;
                SHIFT: begin
                    if (start) begin
                        restart = 1'b1;
                    end else if (cnt_last) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Hold register loads the word including the bit sampled on this edge.
    always_comb begin
        p_out_d     = p_out_q;
        p_valid_d   = p_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q | restart;
        if (word_done) begin
            if (!p_valid_q || p_ready) begin
                p_out_d   = sh_d;
                p_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            p_out_q     <= '0;
            p_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            p_out_q     <= p_out_d;
            p_valid_q   <= p_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign p_out     = p_out_q;
    assign p_valid   = p_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
